// File: rtl/i2c_slave_responder.sv
// I2C target at SLAVE_ADDR: oversampled SCL/SDA, open-drain SDA, single/multi-byte reads and writes.
// Bus events act 3 clk after the pin change; no flow control beyond I2C ACK/NACK.
module i2c_slave_responder #(
  parameter logic [6:0] SLAVE_ADDR = 7'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP
  } state_t;

  state_t     state;
  logic [1:0] scl_sync, sda_sync;
  logic       scl_d, sda_d;
  logic [7:0] shreg;
  logic [2:0] cnt;
  logic       rw;
  logic       ack_phase;

  logic scl, sda;
  logic start_ev, stop_ev, scl_rise, scl_fall;

  assign scl      = scl_sync[1];
  assign sda      = sda_sync[1];
  assign start_ev = scl & scl_d & sda_d & ~sda;
  assign stop_ev  = scl & scl_d & ~sda_d & sda;
  assign scl_rise = scl & ~scl_d;
  assign scl_fall = ~scl & scl_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync  <= 2'b11;
      sda_sync  <= 2'b11;
      scl_d     <= 1'b1;
      sda_d     <= 1'b1;
      state     <= IDLE;
      sda_oe    <= 1'b0;
      tx_load   <= 1'b0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      busy      <= 1'b0;
      shreg     <= 8'h00;
      cnt       <= 3'd0;
      rw        <= 1'b0;
      ack_phase <= 1'b0;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
      scl_d    <= scl;
      sda_d    <= sda;
      tx_load  <= 1'b0;
      rx_valid <= 1'b0;

      if (stop_ev) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else if (start_ev) begin
        state  <= ADDR;
        cnt    <= 3'd0;
        sda_oe <= 1'b0;
      end else begin
        case (state)
          IDLE: sda_oe <= 1'b0;

          ADDR: if (scl_rise) begin
            shreg <= {shreg[6:0], sda};
            cnt   <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              // shreg[6:0] holds the seven address bits; sda is R/W
              if (shreg[6:0] == SLAVE_ADDR) begin
                state     <= ADDR_ACK;
                busy      <= 1'b1;
                rw        <= sda;
                ack_phase <= 1'b0;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end

          ADDR_ACK: if (scl_fall) begin
            if (!ack_phase) begin
              sda_oe    <= 1'b1;
              ack_phase <= 1'b1;
            end else begin
              ack_phase <= 1'b0;
              cnt       <= 3'd0;
              if (rw) begin
                tx_load <= 1'b1;
                shreg   <= {tx_data[6:0], 1'b0};
                sda_oe  <= ~tx_data[7];
                state   <= READ;
              end else begin
                sda_oe <= 1'b0;
                state  <= WRITE;
              end
            end
          end

          WRITE: if (scl_rise) begin
            shreg <= {shreg[6:0], sda};
            cnt   <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              rx_data   <= {shreg[6:0], sda};
              rx_valid  <= 1'b1;
              ack_phase <= 1'b0;
              state     <= WRITE_ACK;
            end
          end

          WRITE_ACK: if (scl_fall) begin
            if (!ack_phase) begin
              sda_oe    <= 1'b1;
              ack_phase <= 1'b1;
            end else begin
              sda_oe    <= 1'b0;
              ack_phase <= 1'b0;
              cnt       <= 3'd0;
              state     <= WRITE;
            end
          end

          // shreg[7] always holds the next bit to present
          READ: if (scl_fall) begin
            if (cnt == 3'd7) begin
              sda_oe    <= 1'b0;
              ack_phase <= 1'b0;
              state     <= READ_ACK;
            end else begin
              sda_oe <= ~shreg[7];
              shreg  <= {shreg[6:0], 1'b0};
              cnt    <= cnt + 3'd1;
            end
          end

          READ_ACK: begin
            if (scl_rise && !ack_phase) begin
              if (sda) begin
                state  <= WAIT_STOP;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
              end else begin
                ack_phase <= 1'b1;
              end
            end else if (scl_fall && ack_phase) begin
              tx_load   <= 1'b1;
              shreg     <= {tx_data[6:0], 1'b0};
              sda_oe    <= ~tx_data[7];
              cnt       <= 3'd0;
              ack_phase <= 1'b0;
              state     <= READ;
            end
          end

          WAIT_STOP: sda_oe <= 1'b0;

          default: begin
            state  <= IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed and randomized I2C transactions against a transaction-level model of the target.
module tb_i2c_slave_responder;
  localparam logic [6:0] SA = 7'h20;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_m, sda_m;
  logic       sda_oe, tx_load, rx_valid, busy;
  logic [7:0] tx_data, rx_data;
  logic       sda_bus;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_slave_responder #(.SLAVE_ADDR(SA)) dut (
    .clk(clk), .reset(reset), .scl_in(scl_m), .sda_in(sda_bus), .sda_oe(sda_oe),
    .tx_data(tx_data), .tx_load(tx_load), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int rx_cnt = 0, tx_cnt = 0, oe_rise_hi = 0;
  logic [7:0] rx_last = 8'h00;
  logic oe_prev = 1'b0;

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt++;
      rx_last = rx_data;
    end
    if (tx_load) tx_cnt++;
    if (sda_oe && !oe_prev && scl_m) oe_rise_hi++;
    oe_prev = sda_oe;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    if (scl_m == 1'b0) begin
      tick(4); sda_m = 1'b1;
      tick(4); scl_m = 1'b1;
    end
    tick(8); sda_m = 1'b0;
    tick(8); scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    tick(4); sda_m = 1'b0;
    tick(4); scl_m = 1'b1;
    tick(8); sda_m = 1'b1;
    tick(8);
  endtask

  task automatic clock_bit(input logic b, output logic r);
    tick(6); sda_m = b;
    tick(2); scl_m = 1'b1;
    tick(4); r = sda_bus;
    tick(4); scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], r);
    clock_bit(1'b1, r);
    ack = ~r;
  endtask

  // junk is put on tx_data after the first bit: it must not reach the bus
  task automatic recv_byte(input logic [7:0] junk, output logic [7:0] b);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, r);
      b[i] = r;
      if (i == 7) tx_data = junk;
    end
  endtask

  initial begin
    logic       ack, r, match, rwb;
    logic [7:0] b, b2, last;
    logic [6:0] a;
    int         rx0, tx0, n;
    logic [7:0] q[$];

    reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1; tx_data = 8'h00;
    tick(3);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_tx_load", tx_load, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    tick(4);

    // single-byte write to our address
    rx0 = rx_cnt;
    bus_start();
    send_byte(8'h40, ack);
    check("w1_addr_ack", ack, 1);
    check("w1_busy", busy, 1);
    send_byte(8'hA5, ack);
    check("w1_data_ack", ack, 1);
    check("w1_rx_pulses", rx_cnt - rx0, 1);
    check("w1_rx_data", rx_last, 8'hA5);
    bus_stop();
    check("w1_busy_after_stop", busy, 0);
    check("w1_oe_after_stop", sda_oe, 0);

    // write to another address: ignored
    rx0 = rx_cnt;
    bus_start();
    send_byte(8'h42, ack);
    check("w2_addr_nack", ack, 0);
    check("w2_busy", busy, 0);
    send_byte(8'h5A, ack);
    check("w2_data_nack", ack, 0);
    check("w2_rx_pulses", rx_cnt - rx0, 0);
    bus_stop();

    // single-byte read, master NACK
    tx0 = tx_cnt;
    tx_data = 8'h3C;
    bus_start();
    send_byte(8'h41, ack);
    check("r1_addr_ack", ack, 1);
    recv_byte(8'hC3, b);
    check("r1_byte", b, 8'h3C);
    clock_bit(1'b1, r);
    check("r1_released_ack_clk", r, 1);
    check("r1_tx_loads", tx_cnt - tx0, 1);
    check("r1_busy_after_nack", busy, 0);
    check("r1_oe_after_nack", sda_oe, 0);
    bus_stop();

    // two-byte read: ACK then NACK
    tx0 = tx_cnt;
    tx_data = 8'h81;
    bus_start();
    send_byte(8'h41, ack);
    check("r2_addr_ack", ack, 1);
    recv_byte(8'h00, b);
    tx_data = 8'h7E;
    clock_bit(1'b0, r);
    recv_byte(8'h18, b2);
    clock_bit(1'b1, r);
    check("r2_byte0", b, 8'h81);
    check("r2_byte1", b2, 8'h7E);
    check("r2_tx_loads", tx_cnt - tx0, 2);
    bus_stop();

    // write, repeated START mid second byte, then read
    rx0 = rx_cnt;
    bus_start();
    send_byte(8'h40, ack);
    send_byte(8'hF0, ack);
    check("rs_data_ack", ack, 1);
    for (int i = 0; i < 4; i++) clock_bit(i[0], r);
    bus_start();
    check("rs_busy_held", busy, 1);
    tx_data = 8'h96;
    send_byte(8'h41, ack);
    check("rs_addr_ack", ack, 1);
    recv_byte(8'h69, b);
    clock_bit(1'b1, r);
    check("rs_read_byte", b, 8'h96);
    check("rs_rx_pulses", rx_cnt - rx0, 1);
    check("rs_rx_data", rx_last, 8'hF0);
    bus_stop();

    // reset while the target is driving the address ACK
    bus_start();
    for (int i = 7; i >= 0; i--) clock_bit(((8'h40 >> i) & 1) != 0, r);
    tick(6);
    check("rst_mid_oe_before", sda_oe, 1);
    reset = 1'b1;
    tick(1);
    check("rst_mid_oe", sda_oe, 0);
    check("rst_mid_rx_data", rx_data, 0);
    check("rst_mid_busy", busy, 0);
    reset = 1'b0;
    tick(4);
    bus_stop();
    bus_start();
    send_byte(8'h40, ack);
    check("rst_after_addr_ack", ack, 1);
    bus_stop();

    // randomized transactions against the model
    for (int it = 0; it < 8; it++) begin
      a = ($urandom_range(0, 1) != 0) ? SA : 7'($urandom);
      rwb = 1'($urandom);
      n = $urandom_range(1, 3);
      match = (a == SA);
      rx0 = rx_cnt;
      tx0 = tx_cnt;
      q.delete();
      for (int k = 0; k < n; k++) q.push_back(8'($urandom));
      if (rwb) tx_data = q[0];
      bus_start();
      send_byte({a, rwb}, ack);
      check("rnd_addr_ack", ack, 32'(match));
      if (!rwb) begin
        last = 8'h00;
        for (int k = 0; k < n; k++) begin
          send_byte(q[k], ack);
          check("rnd_wr_ack", ack, 32'(match));
          last = q[k];
        end
        check("rnd_rx_pulses", rx_cnt - rx0, match ? n : 0);
        if (match) check("rnd_rx_data", rx_last, last);
      end else begin
        for (int k = 0; k < n; k++) begin
          recv_byte(8'($urandom), b);
          check("rnd_rd_byte", b, match ? q[k] : 8'hFF);
          if (k + 1 < n) tx_data = q[k + 1];
          clock_bit(k + 1 == n, r);
        end
        check("rnd_tx_loads", tx_cnt - tx0, match ? n : 0);
      end
      bus_stop();
      check("rnd_busy_idle", busy, 0);
    end

    check("no_oe_assert_while_scl_high", oe_rise_hi, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
